player_motion: RTL and testbench

- Per-frame player state updater that sits directly upstream of the tracer and the map-overlay logic.
- On each frame tick it samples the control buttons, rotates the facing and viewplane vectors, moves the player with per-axis wall collision against map_rom, then commits playerX/Y, facingX/Y and vplaneX/Y atomically.
- Replaces the fixed auto-scroll of playerX in the top level.
- All vectors are signed Q6.10, 16 bits.

---
 rtl/player_motion_if.sv | 26 ++
 rtl/player_motion.sv | 173 +++++++++++++++++
 tb/tb_player_motion.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_if.sv
// Signal bundle between player_motion and the top level (buttons, map query, pose outputs).
// Handshake: frame_tick is accepted only while busy=0; busy stays high until commit;
// done pulses for exactly one cycle, in the same cycle the new pose becomes visible.
interface player_motion_if;
  logic        frame_tick;
  logic        move_fwd, move_back, strafe_l, strafe_r, turn_l, turn_r;
  logic [1:0]  map_val;
  logic [3:0]  map_col, map_row;
  logic        busy, done;
  logic [15:0] playerX, playerY;
  logic [15:0] facingX, facingY;
  logic [15:0] vplaneX, vplaneY;
  logic [2:0]  fsm_state;

  modport master (
    output frame_tick, move_fwd, move_back, strafe_l, strafe_r, turn_l, turn_r, map_val,
    input  map_col, map_row, busy, done, playerX, playerY, facingX, facingY,
           vplaneX, vplaneY, fsm_state
  );

  modport slave (
    input  frame_tick, move_fwd, move_back, strafe_l, strafe_r, turn_l, turn_r, map_val,
    output map_col, map_row, busy, done, playerX, playerY, facingX, facingY,
           vplaneX, vplaneY, fsm_state
  );
endinterface

// File: rtl/player_motion.sv
// Per-frame player pose updater: rotate, move, collide, then commit all six Q6.10 outputs.
// Define PLAYER_COLLISION_EN to check candidate positions against map_rom (CHECK_X/CHECK_Y).
module player_motion #(
  parameter int START_CELL_X = 1,
  parameter int START_CELL_Y = 11,
  parameter int MOVE_SHIFT   = 4,
  parameter int TURN_SHIFT   = 4,
  parameter int COS_SHIFT    = 9
) (
  input logic           clk,
  input logic           reset,
  player_motion_if.slave pm
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROTATE, S_MOVE, S_CHECK_X, S_CHECK_Y, S_COMMIT
  } state_t;

  localparam logic signed [15:0] START_X = 16'(START_CELL_X * 1024 + 512);
  localparam logic signed [15:0] START_Y = 16'(START_CELL_Y * 1024 + 512);

  state_t state, state_nxt;

  logic b_fwd, b_back, b_sl, b_sr, b_tl, b_tr;
  logic signed [15:0] px, py, fx, fy, vx, vy;
  logic signed [15:0] wpx, wpy, wfx, wfy, wvx, wvy;
  logic signed [15:0] dx, dy, cand_x_c, cand_y_c;
  logic done_r;

  // Small-angle rotation; cw=1 turns right with y pointing down-screen.
  function automatic logic signed [15:0] rot_x(input logic signed [15:0] x,
                                               input logic signed [15:0] y,
                                               input logic cw);
    logic signed [15:0] yt;
    yt = y >>> TURN_SHIFT;
    return x - (x >>> COS_SHIFT) - (cw ? yt : -yt);
  endfunction

  function automatic logic signed [15:0] rot_y(input logic signed [15:0] x,
                                               input logic signed [15:0] y,
                                               input logic cw);
    logic signed [15:0] xt;
    xt = x >>> TURN_SHIFT;
    return y - (y >>> COS_SHIFT) + (cw ? xt : -xt);
  endfunction

  function automatic logic signed [15:0] signed_step(input logic signed [15:0] step,
                                                     input logic pos, input logic neg);
    if (pos && !neg) return step;
    if (neg && !pos) return -step;
    return 16'sd0;
  endfunction

  function automatic logic out_of_map(input logic signed [15:0] c);
    return c[15:14] != 2'b00;
  endfunction

  always_comb begin
    dx = signed_step(wfx >>> MOVE_SHIFT, b_fwd, b_back)
       + signed_step(wvx >>> (MOVE_SHIFT - 1), b_sr, b_sl);
    dy = signed_step(wfy >>> MOVE_SHIFT, b_fwd, b_back)
       + signed_step(wvy >>> (MOVE_SHIFT - 1), b_sr, b_sl);
    cand_x_c = wpx + dx;
    cand_y_c = wpy + dy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pm.frame_tick) state_nxt = S_ROTATE;
      S_ROTATE:  state_nxt = S_MOVE;
`ifdef PLAYER_COLLISION_EN
      S_MOVE:    state_nxt = S_CHECK_X;
      S_CHECK_X: state_nxt = S_CHECK_Y;
      S_CHECK_Y: state_nxt = S_COMMIT;
`else
      S_MOVE:    state_nxt = S_COMMIT;
`endif
      S_COMMIT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

`ifdef PLAYER_COLLISION_EN
  logic signed [15:0] cand_x, cand_y;

  always_comb begin
    pm.map_col = 4'd0;
    pm.map_row = 4'd0;
    case (state)
      S_CHECK_X: begin pm.map_col = cand_x[13:10]; pm.map_row = wpy[13:10];    end
      S_CHECK_Y: begin pm.map_col = wpx[13:10];    pm.map_row = cand_y[13:10]; end
      default: ;
    endcase
  end
`else
  logic unused_map;
  assign unused_map = ^pm.map_val;
  assign pm.map_col = 4'd0;
  assign pm.map_row = 4'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {b_fwd, b_back, b_sl, b_sr, b_tl, b_tr} <= 6'b0;
      px  <= START_X;  py  <= START_Y;
      fx  <= 16'sd0;   fy  <= -16'sd1024;
      vx  <= 16'sd512; vy  <= 16'sd0;
      wpx <= START_X;  wpy <= START_Y;
      wfx <= 16'sd0;   wfy <= -16'sd1024;
      wvx <= 16'sd512; wvy <= 16'sd0;
`ifdef PLAYER_COLLISION_EN
      cand_x <= START_X;
      cand_y <= START_Y;
`endif
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (pm.frame_tick) begin
          {b_fwd, b_back, b_sl, b_sr, b_tl, b_tr} <=
            {pm.move_fwd, pm.move_back, pm.strafe_l, pm.strafe_r, pm.turn_l, pm.turn_r};
          wpx <= px; wpy <= py;
          wfx <= fx; wfy <= fy;
          wvx <= vx; wvy <= vy;
        end
        // Opposing turn buttons leave both vectors bit-identical (no cos shrink).
        S_ROTATE: if (b_tl != b_tr) begin
          wfx <= rot_x(wfx, wfy, b_tr);
          wfy <= rot_y(wfx, wfy, b_tr);
          wvx <= rot_x(wvx, wvy, b_tr);
          wvy <= rot_y(wvx, wvy, b_tr);
        end
`ifdef PLAYER_COLLISION_EN
        S_MOVE: begin
          cand_x <= cand_x_c;
          cand_y <= cand_y_c;
        end
        S_CHECK_X: if (!out_of_map(cand_x) && pm.map_val == 2'd0) wpx <= cand_x;
        S_CHECK_Y: if (!out_of_map(cand_y) && pm.map_val == 2'd0) wpy <= cand_y;
`else
        S_MOVE: begin
          if (!out_of_map(cand_x_c)) wpx <= cand_x_c;
          if (!out_of_map(cand_y_c)) wpy <= cand_y_c;
        end
`endif
        S_COMMIT: begin
          px <= wpx; py <= wpy;
          fx <= wfx; fy <= wfy;
          vx <= wvx; vy <= wvy;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pm.busy      = (state != S_IDLE);
  assign pm.done      = done_r;
  assign pm.fsm_state = state;
  assign pm.playerX   = px;
  assign pm.playerY   = py;
  assign pm.facingX   = fx;
  assign pm.facingY   = fy;
  assign pm.vplaneX   = vx;
  assign pm.vplaneY   = vy;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: reset pose, rotation, movement, wall and map-edge rejection, aborts.
// Expectations follow the build: PLAYER_COLLISION_EN selects 5-cycle latency and wall blocking.
module tb_player_motion;

`ifdef PLAYER_COLLISION_EN
  localparam int  LAT        = 5;
  localparam bit  COLLIDE    = 1'b1;
`else
  localparam int  LAT        = 3;
  localparam bit  COLLIDE    = 1'b0;
`endif

  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_FWD  = 6'b100000;
  localparam logic [5:0] B_BACK = 6'b010000;
  localparam logic [5:0] B_SL   = 6'b001000;
  localparam logic [5:0] B_SR   = 6'b000100;
  localparam logic [5:0] B_TL   = 6'b000010;
  localparam logic [5:0] B_TR   = 6'b000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_motion_if pm();
  player_motion dut (.clk(clk), .reset(reset), .pm(pm));

  // Map model: empty map, optional single wall at column 1, row 10.
  logic wall_en;
  assign pm.map_val = (wall_en && pm.map_col == 4'd1 && pm.map_row == 4'd10) ? 2'd1 : 2'd0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_btn(input logic [5:0] b);
    {pm.move_fwd, pm.move_back, pm.strafe_l, pm.strafe_r, pm.turn_l, pm.turn_r} = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pm.frame_tick = 1'b0;
    set_btn(B_NONE);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issues one tick and waits for done; returns with done visible.
  task automatic run_frame(input logic [5:0] b, input bit timing);
    int lat;
    @(negedge clk);
    set_btn(b);
    pm.frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pm.frame_tick = 1'b0;
    set_btn(B_NONE);
    if (timing) check("busy_after_tick", pm.busy, 1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pm.done) lat = k;
    end
    check("latency", lat, LAT);
    if (timing) begin
      check("busy_at_done", pm.busy, 0);
      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", pm.done, 0);
    end
  endtask

  task automatic check_pose(input string tag, input int ex_px, input int ex_py,
                            input int ex_fx, input int ex_fy, input int ex_vx, input int ex_vy);
    check({tag, "_px"}, $signed(pm.playerX), ex_px);
    check({tag, "_py"}, $signed(pm.playerY), ex_py);
    check({tag, "_fx"}, $signed(pm.facingX), ex_fx);
    check({tag, "_fy"}, $signed(pm.facingY), ex_fy);
    check({tag, "_vx"}, $signed(pm.vplaneX), ex_vx);
    check({tag, "_vy"}, $signed(pm.vplaneY), ex_vy);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dones;
    wall_en = 1'b0;
    do_reset();

    // Reset pose, idle outputs
    check_pose("reset", 1536, 11776, 0, -1024, 512, 0);
    check("reset_done", pm.done, 0);
    check("reset_busy", pm.busy, 0);
    check("reset_col", pm.map_col, 0);
    check("reset_row", pm.map_row, 0);

    // Right turn, then forward along the rotated facing
    run_frame(B_TR, 1'b1);
    check_pose("turn_r", 1536, 11776, 64, -1022, 511, 32);
    run_frame(B_FWD, 1'b0);
    check_pose("fwd_after_turn", 1540, 11712, 64, -1022, 511, 32);

    // Left turn; opposing turns cancel
    do_reset();
    run_frame(B_TL, 1'b0);
    check_pose("turn_l", 1536, 11776, -64, -1022, 511, -32);
    do_reset();
    run_frame(B_TL | B_TR, 1'b0);
    check_pose("turn_both", 1536, 11776, 0, -1024, 512, 0);

    // Forward, cancelling forward/back, idle frame, strafe right
    do_reset();
    run_frame(B_FWD, 1'b0);
    check_pose("fwd", 1536, 11712, 0, -1024, 512, 0);
    run_frame(B_FWD | B_BACK, 1'b0);
    check_pose("fwd_back", 1536, 11712, 0, -1024, 512, 0);
    run_frame(B_NONE, 1'b1);
    check_pose("idle_frame", 1536, 11712, 0, -1024, 512, 0);
    run_frame(B_SR, 1'b0);
    check("strafe_r_px", $signed(pm.playerX), 1600);

    // Walk to row 10, then step into the wall cell
    do_reset();
    for (int i = 0; i < 23; i++) run_frame(B_FWD, 1'b0);
    check("pre_wall_py", $signed(pm.playerY), 10304);
    wall_en = 1'b1;
    run_frame(B_FWD, 1'b0);
    check("wall_py", $signed(pm.playerY), COLLIDE ? 10304 : 10240);
    check("wall_px", $signed(pm.playerX), 1536);
    wall_en = 1'b0;

    // Left map edge: X reaches 0, the next step would go negative
    do_reset();
    for (int i = 0; i < 24; i++) run_frame(B_SL, 1'b0);
    check("edge_x0", $signed(pm.playerX), 0);
    run_frame(B_SL, 1'b0);
    check("edge_x_neg", $signed(pm.playerX), 0);
    check("edge_x_py", $signed(pm.playerY), 11776);

    // Bottom map edge: 16384 would leave the 16x16 map
    do_reset();
    for (int i = 0; i < 73; i++) run_frame(B_BACK, 1'b0);
    check("edge_y_max", $signed(pm.playerY), 16320);
    check("edge_y_px", $signed(pm.playerX), 1536);

    // Tick while busy is ignored
    do_reset();
    @(negedge clk);
    set_btn(B_TR);
    pm.frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pm.frame_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pm.frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pm.frame_tick = 1'b0;
    set_btn(B_NONE);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pm.done) dones++;
    end
    check("busy_tick_dones", dones, 1);
    check_pose("busy_tick", 1536, 11776, 64, -1022, 511, 32);

    // Reset mid-update aborts with no partial commit
    do_reset();
    @(negedge clk);
    set_btn(B_TR | B_FWD);
    pm.frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pm.frame_tick = 1'b0;
    set_btn(B_NONE);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_pose("abort", 1536, 11776, 0, -1024, 512, 0);
    check("abort_busy", pm.busy, 0);
    check("abort_done", pm.done, 0);
    repeat (LAT + 2) @(negedge clk);
    check_pose("abort_hold", 1536, 11776, 0, -1024, 512, 0);
    reset = 1'b1;
    @(negedge clk);
    run_frame(B_TR, 1'b1);
    check_pose("after_abort", 1536, 11776, 64, -1022, 511, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
